uart_rx_axis: RTL and testbench
===============================

# uart_rx_axis

UART receiver that deserialises an asynchronous serial line into bytes on an AXI4-Stream master port. It sits downstream of `uart_baud` and consumes that block's 16x-oversample `rx_clk` tick as its sampling strobe. Each received frame is 1 start bit, DATA_BITS data bits sent LSB first, and 1 stop bit. A one-entry holding register decouples the line from stream backpressure and reports framing and overrun errors.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..8.
- `OVERSAMPLE`, default 16: `rx_tick` pulses per bit period; must match `uart_baud`; even, at least 8.
- `clk`  in  1  system clock; single clock domain.
- `rstn`  in  1  reset; asynchronous assert, active-low.
- `rx_tick`  in  1  one-`clk` strobe at OVERSAMPLE x baud (from `uart_baud.rx_clk`).
- `rxd`  in  1  asynchronous serial input; idle high.
- `m_axis_tdata`  out  DATA_BITS  received byte.
- `m_axis_tvalid`  out  1  holding register full.
- `m_axis_tready`  in  1  downstream accept.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good frame dropped because the holding register was full.

## Operation
**Input synchroniser**
- `rxd` passes through a 2-flop synchroniser to produce `rxd_s`.
- Both flops reset to 1.
- All FSM decisions use `rxd_s`.

**Counters**
- `tick_cnt`: log2(OVERSAMPLE) bits. It advances only on `rx_tick`, wraps modulo OVERSAMPLE, and clears on every state change.
- `bit_cnt`: counts data bits received.

**FSM.** All transitions are evaluated only on cycles where `rx_tick` = 1. In every state, `tick_cnt` increments on `rx_tick` unless the state changes on that tick.
- IDLE: `rxd_s` = 0 → START.
- START: at `tick_cnt` = OVERSAMPLE/2−1 (mid start bit):
  - `rxd_s` = 0 → DATA, `bit_cnt` = 0.
  - `rxd_s` = 1 → IDLE (glitch rejected, no flag).
- DATA: at `tick_cnt` = OVERSAMPLE−1:
  - Shift `rxd_s` into the MSB of `shreg`, shifting right, so bits land LSB first.
  - `bit_cnt`++.
  - After the DATA_BITS-th bit → STOP.
- STOP: at `tick_cnt` = OVERSAMPLE−1:
  - `rxd_s` = 1 → deliver `shreg`, then go to IDLE.
  - `rxd_s` = 0 → pulse `frame_err`, discard the byte, go to BREAK.
- BREAK: `rxd_s` = 1 → IDLE.
  - A held-low line (break) therefore yields exactly one `frame_err`, not one per frame time.

**Delivery into the holding register**
- If `m_axis_tvalid` = 0, or `m_axis_tvalid & m_axis_tready` in the same cycle:
  - load `m_axis_tdata`;
  - set `m_axis_tvalid` = 1.
- Otherwise:
  - pulse `overrun`;
  - the new byte is lost;
  - `m_axis_tdata` and `m_axis_tvalid` are unchanged.

**Stream handshake**
- `m_axis_tvalid` clears on `tvalid & tready` when there is no simultaneous delivery.
- `m_axis_tdata` is stable while `tvalid` is high and `tready` is low.
- `tvalid` never depends combinationally on `tready`.

**Reset**
- `rstn` low, at any point including mid-frame, forces:
  - state IDLE, all counters 0, `shreg` 0;
  - `m_axis_tdata` = 0, `m_axis_tvalid` = 0;
  - `frame_err` = 0, `overrun` = 0;
  - synchroniser flops = 1.

## Timing
- Synchroniser latency: 2 `clk` from `rxd` to `rxd_s`.
- Sample points: mid start bit is OVERSAMPLE/2 ticks after the falling edge is detected. Every data bit and the stop bit is then sampled a further OVERSAMPLE ticks later, i.e. at mid-bit.
- `m_axis_tvalid` rises, and `frame_err` or `overrun` pulses, on the `clk` edge following the `rx_tick` that samples the stop bit. This is about half a bit before the frame ends.
- A START→IDLE glitch rejection costs no extra ticks. Back-to-back frames with a single stop bit are received with no gaps.
- `rx_tick` is only ever a single-cycle pulse. Behaviour for `rx_tick` held high is undefined.
- Tolerance: data is recovered with up to ±3% baud mismatch for DATA_BITS = 8 and OVERSAMPLE = 16.

## Structure
- Shared package / header `uart_pkg`:
  - state encodings IDLE, START, DATA, STOP, BREAK;
  - default OVERSAMPLE;
  - frame constants (start = 0, stop = 1, idle = 1), so the future transmitter uses identical values.
- One sub-module, `uart_sync`: parameterised 2-flop synchroniser with a reset value, also reused by the transmitter for its CTS input.
- Everything else is flat in `uart_rx_axis`: FSM, counters, shift register, holding register.

## Test plan
Stimulus note: the bench drives `rx_tick` directly every 4 `clk`, so 1 bit = 64 `clk`; `m_axis_tready` = 1 unless stated.
- Frame 0x55, then frame 0xA3 → `tdata` 0x55 then 0xA3; `tvalid` one cycle each; `frame_err` = 0 and `overrun` = 0 throughout.
- `rxd` low for 4 ticks (less than half a bit), then high → FSM returns to IDLE; no `tvalid`, no error pulses.
- Frame 0xA3 with stop bit = 0, line held low 5 bit times, then frame 0x3C → exactly one `frame_err` pulse; no `tvalid` for 0xA3; 0x3C delivered.
- `m_axis_tready` = 0, frames 0x12 then 0x34 back-to-back, `tready` raised 200 `clk` later:
  - one `overrun` pulse at the 0x34 stop sample;
  - `tdata` stays 0x12 until accepted, then `tvalid` falls.
- Delivery coincides with a handshake: `tvalid` high holding 0x12, `tready` pulsed in the same cycle as the 0x34 stop sample → 0x12 accepted, 0x34 loaded, no `overrun`.
- `rstn` asserted during data bit 3 of frame 0xFF, then released, then frame 0x81 → all outputs 0 during reset; 0x81 received correctly with no spurious byte.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and frame constants
package uart_pkg;

    localparam int UART_OVERSAMPLE_DEFAULT = 16;

    // Line levels shared with the transmitter so both ends agree on framing.
    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - parameterised two-flop synchroniser with configurable reset value
module uart_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_axis.sv
// rtl/uart_rx_axis.sv - oversampling UART receiver with one-entry AXI-Stream holding register
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rxd_s;
    uart_state_e          state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [TW-1:0]        tick_inc;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] tdata_q;
    logic                 tvalid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    uart_sync #(
        .WIDTH     (1),
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_rxd_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (rxd),
        .q_o  (rxd_s)
    );

    // Modulo-OVERSAMPLE increment so non-power-of-two ratios still wrap correctly.
    assign tick_inc = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (tvalid_q && m_axis_tready) begin
                tvalid_q <= 1'b0;
            end

            if (rx_tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rxd_s == UART_START_BIT) begin
                            state_q    <= ST_START;
                            tick_cnt_q <= '0;
                        end else begin
                            tick_cnt_q <= tick_inc;
                        end
                    end

                    ST_START: begin
                        if (tick_cnt_q == TICK_HALF) begin
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            state_q    <= (rxd_s == UART_START_BIT) ? ST_DATA : ST_IDLE;
                        end else begin
                            tick_cnt_q <= tick_inc;
                        end
                    end

                    ST_DATA: begin
                        tick_cnt_q <= tick_inc;
                        if (tick_cnt_q == TICK_LAST) begin
                            shreg_q   <= {rxd_s, shreg_q[DATA_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q    <= ST_STOP;
                                tick_cnt_q <= '0;
                            end
                        end
                    end

                    ST_STOP: begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= '0;
                            if (rxd_s == UART_STOP_BIT) begin
                                state_q <= ST_IDLE;
                                // A same-cycle handshake frees the slot, so the new byte may replace it.
                                if (!tvalid_q || m_axis_tready) begin
                                    tdata_q  <= shreg_q;
                                    tvalid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_BREAK;
                            end
                        end else begin
                            tick_cnt_q <= tick_inc;
                        end
                    end

                    ST_BREAK: begin
                        // Held-low line parks here so a break reports only one framing error.
                        if (rxd_s == UART_IDLE_LEVEL) begin
                            state_q    <= ST_IDLE;
                            tick_cnt_q <= '0;
                        end else begin
                            tick_cnt_q <= tick_inc;
                        end
                    end

                    default: begin
                        state_q    <= ST_IDLE;
                        tick_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// tb/tb_uart_rx_axis.sv - directed self-checking bench for uart_rx_axis
module tb_uart_rx_axis;
    import uart_pkg::*;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_tick = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] acc_q[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int valid_cycles = 0;

    uart_rx_axis dut (
        .clk           (clk),
        .rstn          (rstn),
        .rx_tick       (rx_tick),
        .rxd           (rxd),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            rx_tick = (phase == 3);
            phase = (phase + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) acc_q.push_back(m_axis_tdata);
        if (m_axis_tvalid) valid_cycles++;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        wait_clk(BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic clear_mon();
        acc_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        valid_cycles = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        wait_clk(5);
        n_cmp++; if (m_axis_tdata !== 8'h00) begin n_fail++; $display("FAIL reset_tdata: got %h want 00", m_axis_tdata); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        rstn = 1'b1;
        wait_clk(BIT_CLK);
    endtask

    task automatic test_basic();
        clear_mon();
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        wait_clk(BIT_CLK);
        n_cmp++; if (acc_q.size() != 2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", acc_q.size()); end
        n_cmp++; if (acc_q.size() > 0 && acc_q[0] !== 8'h55) begin n_fail++; $display("FAIL basic_byte0: got %h want 55", acc_q[0]); end
        n_cmp++; if (acc_q.size() > 1 && acc_q[1] !== 8'hA3) begin n_fail++; $display("FAIL basic_byte1: got %h want a3", acc_q[1]); end
        n_cmp++; if (valid_cycles != 2) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 2", valid_cycles); end
        n_cmp++; if (fe_cnt != 0) begin n_fail++; $display("FAIL basic_frame_err: got %0d want 0", fe_cnt); end
        n_cmp++; if (ov_cnt != 0) begin n_fail++; $display("FAIL basic_overrun: got %0d want 0", ov_cnt); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rxd = 1'b0;
        wait_clk(16);
        rxd = 1'b1;
        wait_clk(5 * BIT_CLK);
        n_cmp++; if (valid_cycles != 0) begin n_fail++; $display("FAIL glitch_tvalid: got %0d cycles want 0", valid_cycles); end
        n_cmp++; if (fe_cnt != 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt); end
        n_cmp++; if (ov_cnt != 0) begin n_fail++; $display("FAIL glitch_overrun: got %0d want 0", ov_cnt); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL glitch_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_framing();
        clear_mon();
        send_frame(8'hA3, 1'b0);
        rxd = 1'b0;
        wait_clk(4 * BIT_CLK);
        rxd = 1'b1;
        wait_clk(BIT_CLK);
        send_frame(8'h3C, 1'b1);
        wait_clk(BIT_CLK);
        n_cmp++; if (fe_cnt != 1) begin n_fail++; $display("FAIL framing_err_count: got %0d want 1", fe_cnt); end
        n_cmp++; if (acc_q.size() != 1) begin n_fail++; $display("FAIL framing_count: got %0d want 1", acc_q.size()); end
        n_cmp++; if (acc_q.size() > 0 && acc_q[0] !== 8'h3C) begin n_fail++; $display("FAIL framing_byte: got %h want 3c", acc_q[0]); end
        n_cmp++; if (ov_cnt != 0) begin n_fail++; $display("FAIL framing_overrun: got %0d want 0", ov_cnt); end
    endtask

    task automatic test_overrun();
        clear_mon();
        m_axis_tready = 1'b0;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        n_cmp++; if (ov_cnt != 1) begin n_fail++; $display("FAIL overrun_count: got %0d want 1", ov_cnt); end
        n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL overrun_tvalid: got %b want 1", m_axis_tvalid); end
        n_cmp++; if (m_axis_tdata !== 8'h12) begin n_fail++; $display("FAIL overrun_tdata: got %h want 12", m_axis_tdata); end
        wait_clk(200);
        n_cmp++; if (m_axis_tdata !== 8'h12) begin n_fail++; $display("FAIL overrun_hold_tdata: got %h want 12", m_axis_tdata); end
        n_cmp++; if (acc_q.size() != 0) begin n_fail++; $display("FAIL overrun_early_accept: got %0d want 0", acc_q.size()); end
        m_axis_tready = 1'b1;
        wait_clk(2);
        n_cmp++; if (acc_q.size() != 1) begin n_fail++; $display("FAIL overrun_accept_count: got %0d want 1", acc_q.size()); end
        n_cmp++; if (acc_q.size() > 0 && acc_q[0] !== 8'h12) begin n_fail++; $display("FAIL overrun_accept_byte: got %h want 12", acc_q[0]); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL overrun_tvalid_fall: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (ov_cnt != 1) begin n_fail++; $display("FAIL overrun_pulse_len: got %0d want 1", ov_cnt); end
    endtask

    task automatic pulse_ready_at_stop(output bit found);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk);
            #2;
            if (rx_tick && dut.state_q == ST_STOP && dut.tick_cnt_q == 4'd15) begin
                found = 1'b1;
                m_axis_tready = 1'b1;
                @(posedge clk);
                #2;
                m_axis_tready = 1'b0;
            end
        end
    endtask

    task automatic test_coincide();
        bit found;
        clear_mon();
        m_axis_tready = 1'b0;
        send_frame(8'h12, 1'b1);
        fork
            send_frame(8'h34, 1'b1);
            pulse_ready_at_stop(found);
        join
        n_cmp++; if (!found) begin n_fail++; $display("FAIL coincide_stop_sample: got not-seen want seen"); end
        n_cmp++; if (m_axis_tdata !== 8'h34) begin n_fail++; $display("FAIL coincide_loaded: got %h want 34", m_axis_tdata); end
        m_axis_tready = 1'b1;
        wait_clk(BIT_CLK);
        n_cmp++; if (acc_q.size() != 2) begin n_fail++; $display("FAIL coincide_count: got %0d want 2", acc_q.size()); end
        n_cmp++; if (acc_q.size() > 0 && acc_q[0] !== 8'h12) begin n_fail++; $display("FAIL coincide_byte0: got %h want 12", acc_q[0]); end
        n_cmp++; if (acc_q.size() > 1 && acc_q[1] !== 8'h34) begin n_fail++; $display("FAIL coincide_byte1: got %h want 34", acc_q[1]); end
        n_cmp++; if (ov_cnt != 0) begin n_fail++; $display("FAIL coincide_overrun: got %0d want 0", ov_cnt); end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        wait_clk(BIT_CLK / 2);
        rstn = 1'b0;
        wait_clk(2);
        n_cmp++; if (m_axis_tdata !== 8'h00) begin n_fail++; $display("FAIL midreset_tdata: got %h want 00", m_axis_tdata); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midreset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_overrun: got %b want 0", overrun); end
        wait_clk(8);
        rstn = 1'b1;
        wait_clk(6 * BIT_CLK);
        send_frame(8'h81, 1'b1);
        wait_clk(BIT_CLK);
        n_cmp++; if (acc_q.size() != 1) begin n_fail++; $display("FAIL midreset_count: got %0d want 1", acc_q.size()); end
        n_cmp++; if (acc_q.size() > 0 && acc_q[0] !== 8'h81) begin n_fail++; $display("FAIL midreset_byte: got %h want 81", acc_q[0]); end
        n_cmp++; if (fe_cnt != 0) begin n_fail++; $display("FAIL midreset_frame_err_cnt: got %0d want 0", fe_cnt); end
        n_cmp++; if (ov_cnt != 0) begin n_fail++; $display("FAIL midreset_overrun_cnt: got %0d want 0", ov_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_coincide();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
